// File: rtl/md_pkg.sv
// Shared encodings and default latencies for the multiply/divide unit.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    HL_NONE = 2'd0,
    HL_HI   = 2'd1,
    HL_LO   = 2'd2
  } hl_sel_e;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

endpackage

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit: owns HI/LO, models mult/div latency
// with a down-counter and exports busy for the hazard unit.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [1:0]  hl_sel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hl_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // state  | meaning
  // S_IDLE | accepting mult/div/mthi/mtlo
  // S_RUN  | multi-cycle op in flight, r_cnt counts down to write-back
  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e      r_state;
  logic [3:0]  r_cnt;
  logic [2:0]  r_op;
  logic [31:0] r_a, r_b, r_hi, r_lo;
  logic        r_busy;

  logic signed [63:0] w_a_sx, w_b_sx, w_prod_s;
  logic [63:0]        w_prod_u;
  logic [31:0]        w_quot, w_rem, w_res_hi, w_res_lo;
  logic               w_div_zero, w_div_ovf, w_is_div;

  always_comb begin
    w_a_sx     = {{32{r_a[31]}}, r_a};
    w_b_sx     = {{32{r_b[31]}}, r_b};
    w_prod_s   = w_a_sx * w_b_sx;
    w_prod_u   = {32'd0, r_a} * {32'd0, r_b};
    w_is_div   = (r_op == MD_DIV) || (r_op == MD_DIVU);
    w_div_zero = (r_b == 32'd0);
    // INT_MIN / -1 wraps to INT_MIN with zero remainder instead of trapping.
    w_div_ovf  = (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF);
    w_quot     = 32'd0;
    w_rem      = 32'd0;
    if (!w_div_zero) begin
      if (r_op == MD_DIV) begin
        if (w_div_ovf) begin
          w_quot = 32'h8000_0000;
          w_rem  = 32'd0;
        end else begin
          w_quot = 32'($signed(r_a) / $signed(r_b));
          w_rem  = 32'($signed(r_a) % $signed(r_b));
        end
      end else begin
        w_quot = r_a / r_b;
        w_rem  = r_a % r_b;
      end
    end
    w_res_hi = w_prod_u[63:32];
    w_res_lo = w_prod_u[31:0];
    case (r_op)
      MD_MULT: begin
        w_res_hi = w_prod_s[63:32];
        w_res_lo = w_prod_s[31:0];
      end
      MD_DIV, MD_DIVU: begin
        w_res_hi = w_rem;
        w_res_lo = w_quot;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_op    <= 3'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (mdop)
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                r_op    <= mdop;
                r_a     <= a;
                r_b     <= b;
                r_cnt   <= (mdop == MD_MULT || mdop == MD_MULTU) ?
                           4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                r_busy  <= 1'b1;
                r_state <= S_RUN;
              end
              MD_MTHI: r_hi <= a;
              MD_MTLO: r_lo <= a;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
            // A divide by zero still burns its cycles but leaves HI/LO alone.
            if (!(w_is_div && w_div_zero)) begin
              r_hi <= w_res_hi;
              r_lo <= w_res_lo;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    case (hl_sel)
      HL_HI:   hl_out = r_hi;
      HL_LO:   hl_out = r_lo;
      default: hl_out = 32'd0;
    endcase
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: doc/md_unit.md
# md_unit

Execute-stage multiply/divide unit of the five-stage MIPS pipeline. Owns the HI/LO architectural registers and models multi-cycle `mult`/`multu`/`div`/`divu` latency with a busy flag that the hazard unit uses to stall. Provides `hl_out`, the `mfhi`/`mflo` read value that the E/M pipeline register captures as the E-stage HL value, and performs the `mthi`/`mtlo` writes.

## Interface
- `MULT_CYCLES`, 5: busy cycles for `mult`/`multu`.
- `DIV_CYCLES`, 10: busy cycles for `div`/`divu`.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  E-stage instruction is a mult/div/mthi/mtlo; qualifies `mdop`.
- `mdop`  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo.
- `hl_sel`  in  2  0 none, 1 read HI (`mfhi`), 2 read LO (`mflo`).
- `a`  in  32  forwarded rs operand.
- `b`  in  32  forwarded rt operand.
- `busy`  out  1  multi-cycle operation in flight.
- `hl_out`  out  32  HI if `hl_sel`=1, LO if 2, else 0. Combinational from the registers.
- `hi`  out  32  current HI register.
- `lo`  out  32  current LO register.

## Operation
- FSM: IDLE and RUN, plus a down-counter `cnt` (4 bits).
- IDLE, `start` with `mdop` 1–4:
  - latch `a`, `b` and `mdop`.
  - `cnt` ← MULT_CYCLES or DIV_CYCLES.
  - go to RUN.
- RUN:
  - `cnt` decrements each cycle.
  - On the edge where `cnt`=1, write HI/LO, clear `busy` and return to IDLE.
  - The result is computed from the latched operands, not the live `a`/`b`.
- Arithmetic:
  - mult: signed 32×32→64; HI=[63:32], LO=[31:0].
  - multu: the same, unsigned.
  - div: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - divu: unsigned.
- Divide by zero: the operation still takes DIV_CYCLES. HI/LO are left unchanged.
- mthi/mtlo (`mdop` 5/6) in IDLE: HI or LO ← `a` at the edge. No busy; zero latency.
- `start` in RUN with any `mdop`: ignored. The hazard unit guarantees this cannot occur; the bench flags it as a protocol error.
- `mdop` 0 or 7 with `start`: no-op.
- `hl_sel` reads in RUN return the old HI/LO. The hazard unit stalls mfhi/mflo while `start|busy`.

## Timing
- Reset values: `busy`=0, HI=0, LO=0, `hl_out`=0, state IDLE, `cnt`=0.
- `start` for a mult sampled at edge T:
  - `busy`=1 in cycles T+1 … T+5.
  - New HI/LO are visible and `busy`=0 after edge T+5.
  - An `mfhi` issued in the cycle after that reads the result.
- Division follows the same pattern: `busy` high for 10 cycles.
- Back-to-back: a `start` in the first IDLE cycle after completion is accepted.
- Hazard unit stall condition: (`start` in E with `mdop` 1–4) OR `busy`, while the D-stage instruction is any md-class op. Evaluating this is the hazard unit's job; this block only exports `busy`.
- `reset` mid-RUN:
  - aborts the operation.
  - HI/LO are cleared, not written with the partial result.
  - `busy`=0 on the next cycle.
- `reset` with `start` high in the same cycle: `reset` wins and nothing is latched.

## Structure
- Shared package `md_pkg`: `mdop` encodings (MD_NONE … MD_MTLO), `hl_sel` encodings, default latencies.
- The FSM state encoding is local.
- No sub-module. Arithmetic is behavioural `*`, `/` and `%` on the latched operands, with `$signed` for the signed ops. The latency is modelled by the counter, not by the datapath.

## Test plan
- mult a=0xFFFFFFFF, b=2 → `busy` high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu a=0xFFFFFFFF, b=2 → HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- div a=0xFFFFFFF9 (−7), b=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu a=7, b=2 → LO=3, HI=1.
- Divide by zero: preload HI=0x11, LO=0x22 via mthi/mtlo, then divu a=5, b=0 → `busy` for 10 cycles; HI=0x11, LO=0x22 unchanged.
- mthi a=0xDEADBEEF then `hl_sel`=1 → `hl_out`=0xDEADBEEF the next cycle, `busy` never asserted. During a mult, `hl_sel`=2 returns the old LO.
- Start mult a=3, b=4 and assert `reset` at busy cycle 3 → next cycle `busy`=0, HI=LO=0, and 12 is never written. A fresh mult a=3, b=4 afterwards → LO=12 after 5 cycles.
